// File: rtl/seq_det_scheduler.sv
// Purpose : round-robin shares one serial "1010" detector among N word requesters
//           and returns (requester id, match count) for every word.
// Latency : W cycles from the request handshake to res_valid. Throughput is at most
//           one word per W+2 cycles.
// Backpressure: res_valid holds the result stable until res_ready. No grant is issued
//               while a word is shifting or a result is pending.
// Ports   : clk, reset (async, active-low); req_valid/req_data/req_ready (N requesters);
//           det_reset/det_in/det_out (shared detector); res_valid/res_id/res_count/res_ready.
module seq_det_scheduler #(
  parameter int N = 2,
  parameter int W = 8,
  localparam int ID_W  = (N > 1) ? $clog2(N) : 1,
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req_valid,
  input  logic [N*W-1:0]    req_data,
  output logic [N-1:0]      req_ready,
  output logic              det_reset,
  output logic              det_in,
  input  logic              det_out,
  output logic              res_valid,
  output logic [ID_W-1:0]   res_id,
  output logic [CNT_W-1:0]  res_count,
  input  logic              res_ready
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [W-1:0]      shreg_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [CNT_W-1:0]  res_count_q;
  logic [ID_W-1:0]   res_id_q;
  logic              res_valid_q;

  logic [N-1:0]      grant;
  logic [ID_W-1:0]   grant_id;
  logic              grant_found;
  int                idx;

  // Search starts one past the last winner, so the last winner has the lowest priority.
  always_comb begin
    grant       = '0;
    grant_id    = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(rr_ptr_q) + k) % N;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Gated with reset so that no requester sees a grant while the block is held in reset.
  assign req_ready = (state_q == IDLE && reset) ? grant : '0;

  // Keeping the detector cleared outside SHIFT makes each word start from a fresh state.
  assign det_reset = (state_q != SHIFT);
  assign det_in    = (state_q == SHIFT) ? shreg_q[W-1] : 1'b0;

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_count = res_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(N - 1);
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      res_count_q <= '0;
      res_id_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            shreg_q     <= req_data[int'(grant_id)*W +: W];
            bit_cnt_q   <= CNT_W'(W - 1);
            res_count_q <= '0;
            res_id_q    <= grant_id;
            rr_ptr_q    <= grant_id;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          res_count_q <= res_count_q + CNT_W'(det_out);
          shreg_q     <= shreg_q << 1;
          bit_cnt_q   <= bit_cnt_q - 1'b1;
          if (bit_cnt_q == '0) begin
            state_q     <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
